round_state_ctrl: RTL

//  Iterative AES-128 encryption round controller. Holds the 128-bit cipher state and applies AddRoundKey.

---
 rtl/round_state_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/round_state_ctrl.sv
// Iterative AES-128 round controller: holds the cipher state, applies AddRoundKey, sequences NR rounds.
// Optional macro ROUND_PIPE_EN registers the round-chain return and makes each round take 2 cycles.
module round_state_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_start,
  input  logic [127:0] i_data,
  input  logic [127:0] i_round_key,
  input  logic [127:0] i_round_result,
  input  logic         i_ack,
  output logic         o_ready,
  output logic [3:0]   o_round_num,
  output logic [127:0] o_sub_in,
  output logic         o_final_round,
  output logic [127:0] o_data,
  output logic         o_valid
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t         state;
  logic [127:0]   state_reg;
  logic [3:0]     round_num;
  logic [127:0]   round_in;
  logic           round_step;

`ifdef ROUND_PIPE_EN
  logic           phase;
  logic [127:0]   result_q;

  // Phase 0 captures the chain return; phase 1 applies the key and advances the round.
  assign round_in   = result_q;
  assign round_step = phase;
`else
  assign round_in   = i_round_result;
  assign round_step = 1'b1;
`endif

  // NOTE: every register here is written with <= so all updates in a cycle see pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      state_reg     <= '0;
      round_num     <= '0;
      o_valid       <= 1'b0;
      o_ready       <= 1'b1;
      o_final_round <= 1'b0;
`ifdef ROUND_PIPE_EN
      phase         <= 1'b0;
      result_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state_reg     <= i_data ^ i_round_key;
            round_num     <= 4'd1;
            o_final_round <= (NR_L == 4'd1);
            o_ready       <= 1'b0;
            state         <= ROUND;
          end
        end
        ROUND: begin
`ifdef ROUND_PIPE_EN
          if (!phase) result_q <= i_round_result;
          phase <= ~phase;
`endif
          if (round_step) begin
            state_reg <= round_in ^ i_round_key;
            if (round_num == NR_L) begin
              state         <= DONE;
              o_valid       <= 1'b1;
              o_final_round <= 1'b0;
            end else begin
              round_num     <= round_num + 4'd1;
              o_final_round <= (round_num + 4'd1 == NR_L);
            end
          end
        end
        DONE: begin
          // A start arriving with the ack is dropped: IDLE is only entered on this edge.
          if (i_ack) begin
            state     <= IDLE;
            round_num <= '0;
            o_valid   <= 1'b0;
            o_ready   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_round_num = round_num;
  assign o_sub_in    = state_reg;
  assign o_data      = o_valid ? state_reg : '0;

endmodule
